// File: rtl/perf_pkg.sv
// perf_pkg: shared encodings for the performance counter block.
// FSM states, command opcodes, read selects and the read response bundle.
package perf_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_CLEAR = 2'd2;

  localparam logic [1:0] OP_NOP   = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_STOP  = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  localparam logic [1:0] SEL_CYC_LO  = 2'd0;
  localparam logic [1:0] SEL_CYC_HI  = 2'd1;
  localparam logic [1:0] SEL_INST_LO = 2'd2;
  localparam logic [1:0] SEL_INST_HI = 2'd3;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } rd_rsp_t;

endpackage

// File: rtl/perf_counter64.sv
// perf_counter64: wrapping up-counter with sync clear (clear beats inc).
// Ports: clk, rst_n, inc, clr in; count value and wrap (inc at max) out.
module perf_counter64 #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign count = cnt_q;
  assign wrap  = inc & ~clr & (&cnt_q);

endmodule

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: cycle/instret counters with START/STOP/CLEAR FSM.
// Ports: clk, rst_n; cmd_valid/cmd_op/cmd_ready command channel;
// inst_valid retire strobe; rd_valid/rd_sel read request;
// rd_resp_valid/rd_data response (1-cycle latency); running; ovf_irq.
// Macro PERF_OVERFLOW_IRQ_EN enables sticky overflow flags and ovf_irq.
module perf_counter_ctrl
  import perf_pkg::*;
#(
  parameter int CNT_W = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  output logic        cmd_ready,
  input  logic        inst_valid,
  input  logic        rd_valid,
  input  logic [1:0]  rd_sel,
  output logic        rd_resp_valid,
  output logic [31:0] rd_data,
  output logic        running,
  output logic        ovf_irq
);

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       acc;
  logic       clr;
  logic       run;

  logic [CNT_W-1:0] cyc_cnt;
  logic [CNT_W-1:0] inst_cnt;
  logic             cyc_wrap;
  logic             inst_wrap;

  logic [31:0] cyc_hi;
  logic [31:0] inst_hi;
  logic [31:0] sh_cyc_q;
  logic [31:0] sh_inst_q;
  logic [31:0] rd_word;
  rd_rsp_t     rsp_q;

  assign cmd_ready = (state_q != ST_CLEAR);
  assign acc       = cmd_valid & cmd_ready;
  assign clr       = acc & (cmd_op == OP_CLEAR);
  assign run       = (state_q == ST_RUN);
  assign running   = run;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ST_CLEAR;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (acc && cmd_op == OP_START)
            state_d = ST_RUN;
        end
        ST_RUN: begin
          if (acc && cmd_op == OP_STOP)
            state_d = ST_IDLE;
        end
        ST_CLEAR: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  perf_counter64 #(.CNT_W(CNT_W)) u_cyc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run),
    .clr   (clr),
    .count (cyc_cnt),
    .wrap  (cyc_wrap)
  );

  perf_counter64 #(.CNT_W(CNT_W)) u_inst (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (run & inst_valid),
    .clr   (clr),
    .count (inst_cnt),
    .wrap  (inst_wrap)
  );

  // Upper counter bits, zero-extended to a 32-bit word.
  always_comb begin
    cyc_hi  = '0;
    inst_hi = '0;
    cyc_hi[CNT_W-33:0]  = cyc_cnt[CNT_W-1:32];
    inst_hi[CNT_W-33:0] = inst_cnt[CNT_W-1:32];
  end

  always_comb begin
    rd_word = '0;
    unique case (rd_sel)
      SEL_CYC_LO:  rd_word = cyc_cnt[31:0];
      SEL_CYC_HI:  rd_word = sh_cyc_q;
      SEL_INST_LO: rd_word = inst_cnt[31:0];
      SEL_INST_HI: rd_word = sh_inst_q;
      default:     rd_word = '0;
    endcase
  end

  // Reads sample pre-edge values, so a same-edge clear still
  // returns the old count while the shadows are zeroed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_q     <= '0;
      sh_cyc_q  <= '0;
      sh_inst_q <= '0;
    end else begin
      rsp_q.valid <= rd_valid;
      if (rd_valid)
        rsp_q.data <= rd_word;
      if (clr) begin
        sh_cyc_q  <= '0;
        sh_inst_q <= '0;
      end else if (rd_valid) begin
        if (rd_sel == SEL_CYC_LO)
          sh_cyc_q <= cyc_hi;
        if (rd_sel == SEL_INST_LO)
          sh_inst_q <= inst_hi;
      end
    end
  end

  assign rd_resp_valid = rsp_q.valid;
  assign rd_data       = rsp_q.data;

`ifdef PERF_OVERFLOW_IRQ_EN
  logic [1:0] ovf_q;
  logic [1:0] ovf_d;
  logic       irq_q;

  assign ovf_d = clr ? 2'b00 : (ovf_q | {inst_wrap, cyc_wrap});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= '0;
      irq_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      irq_q <= |ovf_d;
    end
  end

  assign ovf_irq = irq_q;
`else
  logic unused_wrap;
  assign unused_wrap = cyc_wrap ^ inst_wrap;
  assign ovf_irq     = 1'b0;
`endif

endmodule
